// File: rtl/rle_pkg.sv
// Shared definitions for the RLE instruction stream (encoder and playback decoder).
// Instruction word: [17:8] run length, [7:0] colour; length 0x3FF marks an audio word.
package rle_pkg;

    localparam int unsigned LEN_W    = 10;
    localparam int unsigned COLOUR_W = 8;
    localparam int unsigned INSTR_W  = LEN_W + COLOUR_W;

    localparam logic [INSTR_W-1:0] STOP_CODE = 18'h30000;
    localparam logic [LEN_W-1:0]   AUDIO_LEN = 10'h3FF;
    // A 768-long black run would encode as the stop word, so black is capped one lower.
    localparam logic [LEN_W-1:0]   BLACK_CAP = 10'd767;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_STOP  = 2'd3
    } rle_state_e;

    typedef struct packed {
        logic [LEN_W-1:0]    len;
        logic [COLOUR_W-1:0] colour;
    } rle_instr_t;

    function automatic rle_instr_t make_instr(input logic [LEN_W-1:0]    len,
                                              input logic [COLOUR_W-1:0] colour);
        rle_instr_t w;
        w.len    = len;
        w.colour = colour;
        return w;
    endfunction

endpackage

// File: rtl/rle_out_fifo.sv
// Synchronous output FIFO with registered full/empty flags.
// Head is read straight from storage and forced to zero while empty.
module rle_out_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    // Full is taken from the registered flag, so a same-cycle pop never makes room.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_d;
            empty <= (count_d == '0);
            full  <= (count_d == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/rle_encoder.sv
// Streaming run-length encoder: raster pixels plus audio samples into 18-bit playback
// instructions. Runs close on colour change, length cap or line end; audio slots in between.
module rle_encoder
    import rle_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_RUN    = 1022
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_pixel,
    input  logic        in_last,
    input  logic        in_frame_end,
    input  logic        audio_valid,
    output logic        audio_ready,
    input  logic [7:0]  audio_sample,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] out_instr
);

    rle_state_e          state_q;
    logic [COLOUR_W-1:0] colour_q;
    logic [LEN_W-1:0]    count_q;
    logic                stop_pend_q;
    logic                audio_pend_q;
    logic [COLOUR_W-1:0] audio_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic                open_state;
    logic                beat;
    logic                line_end;
    logic                extend;
    logic                audio_push;
    logic                push;
    logic [LEN_W-1:0]    cap;
    rle_instr_t          push_data;

    assign open_state  = (state_q == ST_EMPTY) || (state_q == ST_RUN);
    assign cap         = (colour_q == '0) ? BLACK_CAP : LEN_W'(MAX_RUN);
    assign in_ready    = !fifo_full && !audio_pend_q && open_state;
    assign audio_ready = !audio_pend_q;
    assign out_valid   = !fifo_empty;
    assign beat        = in_valid && in_ready;
    assign line_end    = in_last || in_frame_end;
    assign extend      = (state_q == ST_RUN) && (in_pixel == colour_q) && (count_q < cap);
    assign audio_push  = audio_pend_q && !fifo_full && open_state;

    // Single push source per cycle: flush/stop word, then pending audio, then the beat.
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        case (state_q)
            ST_FLUSH: begin
                push      = !fifo_full;
                push_data = make_instr(count_q, colour_q);
            end
            ST_STOP: begin
                push      = !fifo_full;
                push_data = rle_instr_t'(STOP_CODE);
            end
            default: begin
                if (audio_push) begin
                    push      = 1'b1;
                    push_data = make_instr(AUDIO_LEN, audio_q);
                end else if (beat) begin
                    if (extend) begin
                        push      = line_end;
                        push_data = make_instr(count_q + LEN_W'(1), colour_q);
                    end else if (state_q == ST_RUN) begin
                        push      = 1'b1;
                        push_data = make_instr(count_q, colour_q);
                    end else begin
                        push      = line_end;
                        push_data = make_instr(LEN_W'(1), in_pixel);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            colour_q     <= '0;
            count_q      <= '0;
            stop_pend_q  <= 1'b0;
            audio_pend_q <= 1'b0;
            audio_q      <= '0;
        end else begin
            if (audio_valid && !audio_pend_q) begin
                audio_pend_q <= 1'b1;
                audio_q      <= audio_sample;
            end else if (audio_push) begin
                audio_pend_q <= 1'b0;
            end

            case (state_q)
                ST_FLUSH: begin
                    if (!fifo_full) begin
                        state_q <= stop_pend_q ? ST_STOP : ST_EMPTY;
                    end
                end
                ST_STOP: begin
                    if (!fifo_full) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: begin
                    if (beat) begin
                        if (extend) begin
                            count_q <= count_q + LEN_W'(1);
                            if (line_end) begin
                                state_q <= in_frame_end ? ST_STOP : ST_EMPTY;
                            end
                        end else begin
                            colour_q <= in_pixel;
                            count_q  <= LEN_W'(1);
                            if (state_q == ST_EMPTY) begin
                                state_q <= in_frame_end ? ST_STOP
                                         : (in_last ? ST_EMPTY : ST_RUN);
                            end else if (line_end) begin
                                // New single-pixel run still has to go out before the line ends.
                                state_q     <= ST_FLUSH;
                                stop_pend_q <= in_frame_end;
                            end else begin
                                state_q <= ST_RUN;
                            end
                        end
                    end
                end
            endcase
        end
    end

    rle_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .head      (out_instr),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_rle_encoder.sv
// Directed and randomized bench for rle_encoder; expected words come from a
// segment/chunk reference model and hand-derived constants.
module tb_rle_encoder;

    localparam int LIMIT = 5000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pixel;
    logic        in_last;
    logic        in_frame_end;
    logic        audio_valid;
    logic        audio_ready;
    logic [7:0]  audio_sample;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_instr;

    logic        rand_mode   = 1'b0;
    logic        ready_force = 1'b0;
    logic        rnd_ready   = 1'b0;

    int          checks    = 0;
    int          failures  = 0;
    int          stall_cnt = 0;

    logic [17:0] got[$];
    logic [17:0] exp_q[$];
    logic [17:0] aud_exp[$];
    logic [7:0]  line_px[$];

    rle_encoder #(
        .FIFO_DEPTH (2),
        .MAX_RUN    (1022)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pixel     (in_pixel),
        .in_last      (in_last),
        .in_frame_end (in_frame_end),
        .audio_valid  (audio_valid),
        .audio_ready  (audio_ready),
        .audio_sample (audio_sample),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr)
    );

    always #5 clk = ~clk;

    assign out_ready = rand_mode ? rnd_ready : ready_force;

    always @(negedge clk) rnd_ready = ($urandom_range(0, 3) != 0);

    // Record every popped word; values are stable between the falling and rising edge.
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) got.push_back(out_instr);
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%05h expected=0x%05h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] p, input logic l, input logic fe);
        int guard;
        guard        = 0;
        in_valid     = 1'b1;
        in_pixel     = p;
        in_last      = l;
        in_frame_end = fe;
        while (!in_ready && guard < LIMIT) begin
            @(negedge clk);
            guard++;
            stall_cnt++;
        end
        if (guard >= LIMIT) check_bit("beat_timeout", in_ready, 1'b1);
        @(negedge clk);
        in_valid     = 1'b0;
        in_last      = 1'b0;
        in_frame_end = 1'b0;
    endtask

    task automatic send_audio(input logic [7:0] s);
        int guard;
        guard        = 0;
        audio_valid  = 1'b1;
        audio_sample = s;
        while (!audio_ready && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= LIMIT) check_bit("audio_timeout", audio_ready, 1'b1);
        @(negedge clk);
        audio_valid = 1'b0;
    endtask

    // Drives line_px as one line, optionally interleaving random audio, then clears it.
    task automatic send_line(input bit fe, input int rate);
        int          n;
        logic [7:0]  s;
        n = line_px.size();
        for (int i = 0; i < n; i++) begin
            if (rate > 0 && int'($urandom_range(0, 99)) < rate) begin
                s = 8'($urandom);
                aud_exp.push_back({10'h3FF, s});
                send_audio(s);
            end
            send_beat(line_px[i], i == n - 1, fe && (i == n - 1));
        end
        line_px.delete();
    endtask

    // Reference: split the line into maximal same-colour segments, chop each by its cap.
    function automatic void model_line(input bit fe);
        int i;
        int j;
        int cap;
        int rem;
        int len;
        i = 0;
        while (i < line_px.size()) begin
            j = i;
            while (j < line_px.size() && line_px[j] == line_px[i]) j++;
            cap = (line_px[i] == 8'h00) ? 767 : 1022;
            rem = j - i;
            while (rem > 0) begin
                len = (rem > cap) ? cap : rem;
                exp_q.push_back({10'(len), line_px[i]});
                rem -= len;
            end
            i = j;
        end
        if (fe) exp_q.push_back(18'h30000);
    endfunction

    task automatic compare_words(input string tag, input int base);
        int n;
        n = got.size() - base;
        check_word($sformatf("%s_count", tag), 18'(n), 18'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < n; k++)
            check_word($sformatf("%s_%0d", tag, k), got[base + k], exp_q[k]);
        exp_q.delete();
    endtask

    task automatic compare_mixed(input int base);
        logic [17:0] pix[$];
        logic [17:0] aud[$];
        for (int k = base; k < got.size(); k++) begin
            if (got[k][17:8] == 10'h3FF) aud.push_back(got[k]);
            else pix.push_back(got[k]);
        end
        check_word("rand_pix_count", 18'(pix.size()), 18'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < pix.size(); k++)
            check_word($sformatf("rand_pix_%0d", k), pix[k], exp_q[k]);
        check_word("rand_aud_count", 18'(aud.size()), 18'(aud_exp.size()));
        for (int k = 0; k < aud_exp.size() && k < aud.size(); k++)
            check_word($sformatf("rand_aud_%0d", k), aud[k], aud_exp[k]);
        exp_q.delete();
        aud_exp.delete();
    endtask

    initial begin
        int         base;
        int         nseg;
        int         len;
        int         sel;
        logic [7:0] c;

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_pixel     = 8'h00;
        in_last      = 1'b0;
        in_frame_end = 1'b0;
        audio_valid  = 1'b0;
        audio_sample = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        check_bit("rst_out_valid", out_valid, 1'b0);
        check_word("rst_out_instr", out_instr, 18'h00000);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_audio_ready", audio_ready, 1'b1);

        // Colour change mid-line, no backpressure.
        ready_force = 1'b1;
        base        = got.size();
        stall_cnt   = 0;
        repeat (5) line_px.push_back(8'hE0);
        repeat (3) line_px.push_back(8'h1C);
        send_line(1'b0, 0);
        check_bit("t1_in_ready_after", in_ready, 1'b1);
        check_word("t1_stalls", 18'(stall_cnt), 18'd0);
        repeat (10) @(negedge clk);
        exp_q = '{18'h005E0, 18'h0031C};
        compare_words("t1", base);

        // Black is capped at 767 so no stop-code alias appears.
        base = got.size();
        repeat (800) line_px.push_back(8'h00);
        send_line(1'b0, 0);
        repeat (10) @(negedge clk);
        exp_q = '{18'h2FF00, 18'h02100};
        compare_words("t2", base);

        // Non-black cap at MAX_RUN.
        base = got.size();
        repeat (1030) line_px.push_back(8'h03);
        send_line(1'b0, 0);
        repeat (10) @(negedge clk);
        exp_q = '{18'h3FE03, 18'h00803};
        compare_words("t3", base);

        // Frame end on a fresh single-pixel run: FLUSH then STOP.
        base = got.size();
        repeat (4) send_beat(8'hFF, 1'b0, 1'b0);
        send_beat(8'h12, 1'b1, 1'b1);
        check_bit("t4_ready_flush", in_ready, 1'b0);
        @(negedge clk);
        check_bit("t4_ready_stop", in_ready, 1'b0);
        @(negedge clk);
        check_bit("t4_ready_back", in_ready, 1'b1);
        repeat (10) @(negedge clk);
        exp_q = '{18'h004FF, 18'h00112, 18'h30000};
        compare_words("t4", base);

        // Audio during an open run with the consumer stalled until the FIFO fills.
        ready_force = 1'b0;
        base        = got.size();
        send_beat(8'h55, 1'b0, 1'b0);
        send_beat(8'h55, 1'b0, 1'b0);
        check_bit("t5_audio_ready_idle", audio_ready, 1'b1);
        send_audio(8'h80);
        check_bit("t5_in_ready_audio", in_ready, 1'b0);
        check_bit("t5_audio_ready_pend", audio_ready, 1'b0);
        @(negedge clk);
        check_bit("t5_out_valid", out_valid, 1'b1);
        check_word("t5_head_audio", out_instr, 18'h3FF80);
        check_bit("t5_in_ready_resume", in_ready, 1'b1);
        send_beat(8'h66, 1'b0, 1'b0);
        check_bit("t5_in_ready_full", in_ready, 1'b0);
        send_audio(8'h81);
        check_bit("t5_audio_ready_full", audio_ready, 1'b0);
        check_bit("t5_in_ready_full2", in_ready, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_word("t5_head_hold", out_instr, 18'h3FF80);
            check_bit("t5_valid_hold", out_valid, 1'b1);
        end
        ready_force = 1'b1;
        send_beat(8'h66, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        exp_q = '{18'h3FF80, 18'h00255, 18'h3FF81, 18'h00266};
        compare_words("t5", base);

        // Asynchronous reset with an open run, pending FIFO words and audio.
        ready_force = 1'b0;
        send_beat(8'h22, 1'b0, 1'b0);
        send_beat(8'h33, 1'b0, 1'b0);
        send_audio(8'h99);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("t6_out_valid", out_valid, 1'b0);
        check_word("t6_out_instr", out_instr, 18'h00000);
        check_bit("t6_in_ready", in_ready, 1'b1);
        check_bit("t6_audio_ready", audio_ready, 1'b1);
        @(negedge clk);
        rst_n       = 1'b1;
        ready_force = 1'b1;
        base        = got.size();
        send_beat(8'h44, 1'b0, 1'b0);
        send_beat(8'h44, 1'b0, 1'b0);
        send_beat(8'h45, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        exp_q = '{18'h00244, 18'h00145, 18'h30000};
        compare_words("t6", base);

        // Random frame: random palette/lengths, random audio and consumer stalls.
        rand_mode = 1'b1;
        base      = got.size();
        for (int ln = 0; ln < 4; ln++) begin
            nseg = int'($urandom_range(1, 6));
            for (int s = 0; s < nseg; s++) begin
                sel = int'($urandom_range(0, 3));
                case (sel)
                    0:       c = 8'h00;
                    1:       c = 8'h03;
                    2:       c = 8'hE0;
                    default: c = 8'($urandom);
                endcase
                len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(700, 1100))
                                                  : int'($urandom_range(1, 20));
                repeat (len) line_px.push_back(c);
            end
            model_line(ln == 3);
            send_line(ln == 3, 8);
        end
        rand_mode   = 1'b0;
        ready_force = 1'b1;
        repeat (30) @(negedge clk);
        compare_mixed(base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rle_encoder.md
# rle_encoder

Streaming run-length encoder that converts a raster pixel stream (RRRGGGBB, one pixel per accepted beat) plus an independent audio sample stream into the 18-bit instruction words consumed by the playback decoder. Instruction format: [17:8] run length, [7:0] colour. Audio words are 0x3FF00 | sample, and the frame stop word is 0x30000. The block sits at the front of the content pipeline, ahead of the instruction store/SPI writer, and applies backpressure on both inputs.

## Interface
- FIFO_DEPTH, 2, output instruction FIFO depth (power of two, ≥2)
- MAX_RUN, 1022, maximum colour run length (0x3FF is reserved for audio)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel beat valid
- in_ready  out  1  pixel beat accepted when in_valid && in_ready
- in_pixel  in  8  colour RRRGGGBB
- in_last  in  1  beat is the last pixel of a line
- in_frame_end  in  1  beat is the last pixel of the frame (implies in_last)
- audio_valid  in  1  audio sample offered
- audio_ready  out  1  sample accepted when audio_valid && audio_ready
- audio_sample  in  8  PWM sample
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pops when out_valid && out_ready
- out_instr  out  18  FIFO head instruction

## Operation
- Run register: colour[7:0] and count[9:0]. cap = 767 when colour == 0x00 (length 768 of black would alias the stop word); otherwise cap = MAX_RUN.
- FSM states: EMPTY (no open run), RUN (open run), FLUSH (push open run next), STOP (push 0x30000 next).
- At most one FIFO push per cycle. Priority, highest first: FLUSH/STOP push, pending audio, accepted pixel beat.
- in_ready = !fifo_full && !audio_pend && state ∈ {EMPTY, RUN}.
- Accepted beat in EMPTY: colour = pixel, count = 1.
  - With in_frame_end: push {1, pixel}, go to STOP.
  - With in_last: push {1, pixel}, stay in EMPTY.
  - Otherwise: go to RUN.
- Accepted beat in RUN, pixel == colour and count < cap:
  - count + 1.
  - With in_last: push {count+1, colour}, go to EMPTY, or to STOP if in_frame_end.
- Accepted beat in RUN, pixel ≠ colour or count == cap:
  - Push {count, colour}.
  - Start a new run: colour = pixel, count = 1.
  - With in_last: go to FLUSH and latch frame_end into stop_pend. Otherwise stay in RUN.
- FLUSH: when not full, push {count, colour}, then go to STOP if stop_pend, else EMPTY.
- STOP: when not full, push 0x30000 and go to EMPTY.
- Audio:
  - audio_ready = !audio_pend. An accepted sample sets audio_pend.
  - When audio_pend, !full, and state ∈ {EMPTY, RUN}: push {10'h3FF, sample} and clear audio_pend.
  - Audio may precede the instruction that closes an open run. Audio never splits a run.
- Runs never span lines. Emitted lengths are 1..cap.

## Timing
- Reset values: out_valid 0, out_instr 0, in_ready 1, audio_ready 1. FSM is in EMPTY, FIFO empty, audio_pend 0.
- A push is visible on out_instr/out_valid one cycle after the pushing edge when the FIFO was empty. The head is registered, so there is no combinational path from in_* to out_*.
- fifo_full is a registered flag. A pop in the same cycle does not free space for a push in that cycle.
- in_ready drops for exactly one cycle per FLUSH or STOP state, and for one cycle per audio insertion.
- out_instr holds stable while out_valid && !out_ready.
- Asserting rst_n low mid-run asynchronously discards the open run, pending audio and FIFO contents.

## Structure
- Shared package rle_pkg holds:
  - STOP_CODE 18'h30000
  - AUDIO_LEN 10'h3FF
  - BLACK_CAP 10'd767
  - FSM state encodings
  - the instruction field slices
- The decoder shares rle_pkg.
- One sub-module, rle_out_fifo: synchronous FIFO of width 18 and depth FIFO_DEPTH, with registered full/empty flags.

## Test plan
- 5 × 0xE0 then 3 × 0x1C, last on the 8th beat, out_ready = 1 -> 0x005E0 then 0x0031C. in_ready stays 1 throughout.
- 800 × 0x00 with last -> 0x2FF00 then 0x02100. No 0x30000 appears.
- 1030 × 0x03 with last -> 0x3FE03 then 0x00803.
- 4 × 0xFF then 0x12 with in_frame_end -> 0x004FF, 0x00112, 0x30000. in_ready is 0 for the FLUSH and STOP cycles.
- audio_valid with sample 0x80 during an open run, out_ready held 0 until the FIFO fills -> 0x3FF80 is pushed. in_ready and audio_ready deassert when full. Order and values are intact after release.
- Reset pulse mid-run -> outputs return to their reset values immediately, and the next frame encodes cleanly.
